bcd_counter_n: RTL and testbench

//  - Parametrised N-digit BCD up/down counter; next generation of the single-digit decimal counter.
//  - Runs on the fast system clock, advancing only on a one-cycle enable strobe, so no derived clocks.
//  - Adds synchronous load, wrap or saturate modes, and cascade/overflow flags.
//  - Output digits feed the seven-segment scan driver directly, 4 bits per digit.

---
 rtl/cu_pkg.sv | 32 +++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter_n.sv | 87 ++++++++
 tb/tb_bcd_counter_n.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared BCD types and digit arithmetic helpers for the counter codebase.
//   bcd_t      : one BCD digit, 4 bits
//   BCD_MAX    : largest legal digit value (9)
//   bcd_clamp  : min(x, 9), applied to loaded nibbles
//   bcd_inc    : up-step of one digit, 9 (or any illegal code) rolls to 0
//   bcd_dec    : down-step of one digit, 0 rolls to 9, illegal codes go to 0
package cu_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  function automatic bcd_t bcd_clamp(input bcd_t x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t x);
    return (x >= BCD_MAX) ? BCD_ZERO : x + 4'd1;
  endfunction

  // An out-of-range code is treated as corrupted and recovers to 0
  // rather than walking down through other illegal codes.
  function automatic bcd_t bcd_dec(input bcd_t x);
    bcd_t r;
    if (x == BCD_ZERO)     r = BCD_MAX;
    else if (x > BCD_MAX)  r = BCD_ZERO;
    else                   r = x - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register of the N-digit counter.
// Ports:
//   clk      in   system clock, state changes on posedge
//   reset    in   asynchronous active-high reset, forces rst_val
//   rst_val  in   [3:0] digit value applied while reset is high
//   load     in   synchronous load of ld_val (clamped to 9), beats step
//   ld_val   in   [3:0] digit value to load
//   step     in   advance this digit one place this cycle
//   dec      in   step direction: 0 = up, 1 = down
//   q        out  [3:0] registered digit value
//   at9      out  digit currently equals 9
//   at0      out  digit currently equals 0
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rst_val,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       dec,
  output logic [3:0] q,
  output logic       at9,
  output logic       at0
);
  import cu_pkg::*;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= rst_val;
    end else if (load) begin
      q <= bcd_clamp(ld_val);
    end else if (step) begin
      q <= dec ? bcd_dec(q) : bcd_inc(q);
    end
  end

  assign at9 = (q == BCD_MAX);
  assign at0 = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit BCD up/down counter with load, wrap/saturate and
// cascade flags. Runs on the system clock and advances on an enable strobe.
// Parameters:
//   DIGITS       number of BCD digits (1..8)
//   WRAP         1 = wrap at limits, 0 = saturate at limits
//   RESET_VALUE  BCD value forced by reset, 4*DIGITS bits
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   en          in   count strobe, one step per cycle while high
//   dec         in   direction: 0 = up, 1 = down
//   load        in   synchronous load of load_value, overrides en
//   load_value  in   [4*DIGITS-1:0] BCD value to load, digit 0 in [3:0]
//   digits      out  [4*DIGITS-1:0] registered BCD value
//   carry       out  up-step requested at all 9s (combinational)
//   borrow      out  down-step requested at zero (combinational)
//   at_max      out  current value is all 9s
//   at_zero     out  current value is zero
module bcd_counter_n #(
  parameter int unsigned             DIGITS      = 4,
  parameter bit                      WRAP        = 1'b1,
  parameter logic [4*DIGITS-1:0]     RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  carry,
  output logic                  borrow,
  output logic                  at_max,
  output logic                  at_zero
);
  import cu_pkg::*;

  logic [DIGITS-1:0] at9;
  logic [DIGITS-1:0] at0;
  logic [DIGITS-1:0] step;

  logic up_req;
  logic dn_req;
  logic limit;
  logic sat_hold;

  assign at_max  = &at9;
  assign at_zero = &at0;

  assign up_req = en & ~load & ~dec;
  assign dn_req = en & ~load &  dec;

  // A step that would cross the counter's range boundary.
  assign limit = (up_req & at_max) | (dn_req & at_zero);

  assign carry  = ~reset & up_req & at_max;
  assign borrow = ~reset & dn_req & at_zero;

  // Wrapping needs no special handling: every digit rolls over on its own
  // and the ripple chain carries the step through all of them. Saturation
  // is obtained by suppressing the step at the bottom of the chain.
  assign sat_hold = (WRAP == 1'b0) && limit;

  always_comb begin
    step    = '0;
    step[0] = en & ~load & ~sat_hold;
    for (int unsigned k = 1; k < DIGITS; k++) begin
      step[k] = step[k-1] & (dec ? at0[k-1] : at9[k-1]);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VALUE[4*k +: 4]),
      .load    (load),
      .ld_val  (load_value[4*k +: 4]),
      .step    (step[k]),
      .dec     (dec),
      .q       (digits[4*k +: 4]),
      .at9     (at9[k]),
      .at0     (at0[k])
    );
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: a wrapping counter (reset to 0) and a
// saturating counter (reset to 0042) share one stimulus stream. The driver
// applies one directed vector per cycle just after the rising edge and
// queues the hand-computed state/flags expected during that cycle; the
// monitor pops and compares on the falling edge.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        dec = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;

  logic [15:0] digits_w, digits_s;
  logic        carry_w, borrow_w, at_max_w, at_zero_w;
  logic        carry_s, borrow_s, at_max_s, at_zero_s;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1), .RESET_VALUE(16'h0000)) dut_w (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .load(load),
    .load_value(load_value), .digits(digits_w), .carry(carry_w),
    .borrow(borrow_w), .at_max(at_max_w), .at_zero(at_zero_w)
  );

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0), .RESET_VALUE(16'h0042)) dut_s (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .load(load),
    .load_value(load_value), .digits(digits_s), .carry(carry_s),
    .borrow(borrow_s), .at_max(at_max_s), .at_zero(at_zero_s)
  );

  typedef struct {
    logic        rst, en, dec, load;
    logic [15:0] lv;
    logic [15:0] ew, es;
    logic        cw, bw, cs, bs, az, am;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] ew, es;
    logic        cw, bw, cs, bs, az, am;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic mon_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic add(input logic r, input logic e, input logic d, input logic l,
                     input logic [15:0] lv, input logic [15:0] ew, input logic [15:0] es,
                     input logic cw, input logic bw, input logic cs, input logic bs,
                     input logic az, input logic am);
    vec_t v;
    v.rst = r; v.en = e; v.dec = d; v.load = l; v.lv = lv;
    v.ew = ew; v.es = es; v.cw = cw; v.bw = bw; v.cs = cs; v.bs = bs;
    v.az = az; v.am = am;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Monitor: compares whatever the driver queued for the current cycle.
  always @(negedge clk) begin
    if (mon_valid && sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("digits_wrap", x.idx, digits_w, x.ew);
      chk("digits_sat",  x.idx, digits_s, x.es);
      chk("carry_wrap",  x.idx, {15'd0, carry_w},  {15'd0, x.cw});
      chk("borrow_wrap", x.idx, {15'd0, borrow_w}, {15'd0, x.bw});
      chk("carry_sat",   x.idx, {15'd0, carry_s},  {15'd0, x.cs});
      chk("borrow_sat",  x.idx, {15'd0, borrow_s}, {15'd0, x.bs});
      chk("at_zero_wrap", x.idx, {15'd0, at_zero_w}, {15'd0, x.az});
      chk("at_max_wrap",  x.idx, {15'd0, at_max_w},  {15'd0, x.am});
    end
  end

  initial begin
    //   rst en dec ld  load_val   exp_wrap  exp_sat   cw bw cs bs az am
    add(1, 1, 1, 0, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 0, 1, 0); // reset, flags gated
    add(0, 1, 0, 1, 16'h0009, 16'h0000, 16'h0042, 0, 0, 0, 0, 1, 0); // load beats en
    add(0, 1, 0, 0, 16'h0000, 16'h0009, 16'h0009, 0, 0, 0, 0, 0, 0); // 0009 -> 0010
    add(0, 1, 0, 1, 16'h9999, 16'h0010, 16'h0010, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h9999, 16'h9999, 1, 0, 1, 0, 0, 1); // carry at all 9s
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h9999, 0, 0, 0, 0, 1, 0); // wrap vs saturate
    add(0, 1, 1, 0, 16'h0000, 16'h0000, 16'h9999, 0, 1, 0, 0, 1, 0); // borrow at zero
    add(0, 0, 1, 0, 16'h0000, 16'h9999, 16'h9998, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h9999, 16'h9998, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 0); // both borrow
    add(0, 0, 1, 0, 16'h0000, 16'h9999, 16'h0000, 0, 0, 0, 0, 0, 1); // sat holds 0
    add(0, 0, 0, 1, 16'h1000, 16'h9999, 16'h0000, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 16'h0000, 16'h1000, 16'h1000, 0, 0, 0, 0, 0, 0); // 1000 -> 0999
    add(0, 1, 0, 1, 16'h12F4, 16'h0999, 16'h0999, 0, 0, 0, 0, 0, 0); // clamp load
    add(0, 1, 0, 0, 16'h0000, 16'h1294, 16'h1294, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h1295, 16'h1295, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0999, 16'h1296, 16'h1296, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0999, 16'h0999, 0, 0, 0, 0, 0, 0); // 0999 -> 1000
    add(0, 0, 0, 0, 16'h0000, 16'h1000, 16'h1000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h1000, 16'h1000, 0, 0, 0, 0, 0, 0); // free run
    add(0, 1, 0, 0, 16'h0000, 16'h1001, 16'h1001, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 0, 1, 0); // async reset mid-cycle
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 0, 1, 0); // release
    add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0043, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0044, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0003, 16'h0045, 0, 0, 0, 0, 0, 0);

    mon_valid = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      @(posedge clk);
      #1;
      reset      = vecs[i].rst;
      en         = vecs[i].en;
      dec        = vecs[i].dec;
      load       = vecs[i].load;
      load_value = vecs[i].lv;
      x.idx = i + 1;
      x.ew = vecs[i].ew; x.es = vecs[i].es;
      x.cw = vecs[i].cw; x.bw = vecs[i].bw;
      x.cs = vecs[i].cs; x.bs = vecs[i].bs;
      x.az = vecs[i].az; x.am = vecs[i].am;
      sb.push_back(x);
    end

    @(posedge clk);
    #1;
    en   = 1'b0;
    load = 1'b0;

    // Bounded drain of the scoreboard.
    for (int n = 0; n < 4 && sb.size() > 0; n++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
